alu32_result_buf: RTL and testbench
===================================

# alu32_result_buf

Registered result buffer directly downstream of the 32-bit ALU (`alu32`). Captures each ALU result together with its Z/C/V/S flags and the `ALU_Sel` opcode that produced it into a DEPTH-entry FIFO. Presents the entries in order to the writeback consumer over a valid/ready handshake. Optionally accumulates sticky status flags and counts producer stall cycles for debug.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `STALL_W`, 8: width of the stall counter.

- `clk` in 1: single clock, all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `ALU_Out` in 32: ALU result.
- `Z`, `C`, `V`, `S` in 1 each: ALU flags.
- `ALU_Sel` in 4: opcode tag stored with the entry.
- `in_valid` in 1: producer presents a result this cycle.
- `in_ready` out 1: buffer can accept.
- `out_data` out 32: head result.
- `out_flags` out 4: head flags, packed as {Z,C,V,S}.
- `out_sel` out 4: head opcode.
- `out_valid` out 1: head entry is valid.
- `out_ready` in 1: consumer accepts the head.
- `count` out $clog2(DEPTH)+1: occupancy.
- `sticky_flags` out 4: OR of {Z,C,V,S} over all accepted entries since the last clear.
- `flag_clr` in 1: clears `sticky_flags`.
- `stall_cnt` out STALL_W: saturating count of cycles with `in_valid && !in_ready`.

## Operation
- Push occurs when `in_valid && in_ready`. It writes {ALU_Out, Z,C,V,S, ALU_Sel} at `wr_ptr`.
- Pop occurs when `out_valid && out_ready`. It advances `rd_ptr`.
- `in_ready` = (`count` < DEPTH) && !`rst`. There is no pass-through when full: a pop in the same cycle does not free a slot for a push.
- `out_valid` = (`count` != 0).
- `out_data`, `out_flags` and `out_sel` are read from `mem[rd_ptr]`. They are don't-care while `out_valid` is 0, and must hold steady while `out_valid && !out_ready`.
- Count update:
  - push only: `count` +1
  - pop only: `count` −1
  - push and pop together: `count` unchanged, both pointers advance.
- Pointers wrap from DEPTH−1 to 0 and are never compared directly; `count` is authoritative.
- Sticky flags:
  - `flag_clr` and push in the same cycle: `sticky_flags` ← pushed flags.
  - `flag_clr` without push: ← 0.
  - push without `flag_clr`: ← `sticky_flags` | pushed flags.
- `stall_cnt` increments on each cycle with `in_valid && !in_ready` and saturates at all-ones. It is cleared only by `rst`.
- Reset values: `count`=0, pointers=0, `out_valid`=0, `in_ready`=0 while `rst` is high (1 on the first cycle after), `sticky_flags`=0, `stall_cnt`=0. Memory contents are not reset.
- Reset asserted mid-operation discards all entries at the next edge. Handshakes in that cycle are ignored.

## Timing
- Latency is 1 cycle: an entry pushed at edge n is visible with `out_valid`=1 after edge n.
- Full throughput is 1 push and 1 pop per cycle in steady state.
- `in_ready` and `out_valid` depend only on registered `count` (and `rst`). There is no combinational path from `out_ready` to `in_ready` or from `in_valid` to `out_valid`.
- `sticky_flags` and `stall_cnt` update at the same edge as the triggering event.

## Configuration
- `ALU_RESULT_BUF_DEBUG_EN`:
  - Defined: the `sticky_flags` and `stall_cnt` logic is present as described above.
  - Undefined: both outputs are tied to 0, `flag_clr` is ignored, and the associated registers are not synthesized.
  - FIFO behaviour is identical in both builds.

## Test plan
- Single entry: push ALU_Out=0x00000003, Z/C/V/S=0000, ALU_Sel=0000 into an empty buffer with `out_ready`=0 → one cycle later `out_valid`=1, `out_data`=0x00000003, `out_sel`=0000, `count`=1. Raising `out_ready` for 1 cycle → `count`=0, `out_valid`=0.
- Fill and stall: push 5 entries back-to-back (0x3, 0xFFFFFFFF, 0x0, 0xFFFFFFFF, 0x6) with `out_ready`=0 and DEPTH=4 → `count`=4 and `in_ready`=0 after the 4th push; 0x6 is held off and `stall_cnt` increments by 1 per stalled cycle. Popping then yields 0x3, 0xFFFFFFFF, 0x0, 0xFFFFFFFF in order.
- Simultaneous push/pop at `count`=2 over 10 cycles → `count` stays 2, data order is preserved across pointer wrap.
- Sticky flags:
  - push flags {Z,C,V,S}=1000, then 0001 → `sticky_flags`=1001
  - `flag_clr` together with a push of 0100 → `sticky_flags`=0100
  - `flag_clr` alone → 0000
- Reset mid-stream: at `count`=3, assert `rst` for 1 cycle while `in_valid`=1 → `count`=0, `out_valid`=0, `in_ready`=0 during reset and 1 afterwards. The stall counter and sticky flags return to 0.
- Build with `ALU_RESULT_BUF_DEBUG_EN` undefined and rerun the sticky-flags and stall scenarios → `sticky_flags`=0 and `stall_cnt`=0 throughout, FIFO data unchanged.

Source files
------------

// File: rtl/alu32_result_buf_if.sv
// Bus bundle between the ALU producer, the result buffer and the writeback consumer.
// The master side is the producer/consumer pair; the buffer sits on the slave side.
interface alu32_result_buf_if #(
  parameter int DEPTH   = 4,
  parameter int STALL_W = 8
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [31:0]        ALU_Out;
  logic               Z;
  logic               C;
  logic               V;
  logic               S;
  logic [3:0]         ALU_Sel;
  logic               in_valid;
  logic               in_ready;
  logic [31:0]        out_data;
  logic [3:0]         out_flags;
  logic [3:0]         out_sel;
  logic               out_valid;
  logic               out_ready;
  logic [CW-1:0]      count;
  logic [3:0]         sticky_flags;
  logic               flag_clr;
  logic [STALL_W-1:0] stall_cnt;

  // Handshake: a transfer happens on a rising edge where valid && ready are both
  // high; ready never depends combinationally on the opposite side's valid/ready.
  modport master (
    output ALU_Out, Z, C, V, S, ALU_Sel, in_valid, out_ready, flag_clr,
    input  in_ready, out_data, out_flags, out_sel, out_valid, count,
    input  sticky_flags, stall_cnt
  );

  modport slave (
    input  ALU_Out, Z, C, V, S, ALU_Sel, in_valid, out_ready, flag_clr,
    output in_ready, out_data, out_flags, out_sel, out_valid, count,
    output sticky_flags, stall_cnt
  );
endinterface

// File: rtl/alu32_result_buf.sv
// DEPTH-entry FIFO holding ALU results with flags and opcode, valid/ready on both sides.
// Define ALU_RESULT_BUF_DEBUG_EN to build the sticky-flag and stall-counter debug logic.
module alu32_result_buf #(
  parameter int DEPTH   = 4,
  parameter int STALL_W = 8
) (
  input logic              clk,
  input logic              rst,
  alu32_result_buf_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  logic [39:0]   mem [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          in_ready;
  logic          out_valid;
  logic          push;
  logic          pop;

  // Ready/valid come only from registered occupancy, so no pass-through when full.
  assign in_ready  = (count_q < FULL) && !rst;
  assign out_valid = (count_q != '0);
  assign push      = bus.in_valid && in_ready;
  assign pop       = out_valid && bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.count     = count_q;
  assign bus.out_data  = mem[rd_ptr_q][39:8];
  assign bus.out_flags = mem[rd_ptr_q][7:4];
  assign bus.out_sel   = mem[rd_ptr_q][3:0];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is deliberately not reset; count_q alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= {bus.ALU_Out, bus.Z, bus.C, bus.V, bus.S, bus.ALU_Sel};
  end

`ifdef ALU_RESULT_BUF_DEBUG_EN
  logic [3:0]         sticky_q, sticky_d;
  logic [STALL_W-1:0] stall_q, stall_d;
  logic [3:0]         push_flags;

  assign push_flags = {bus.Z, bus.C, bus.V, bus.S};

  always_comb begin
    sticky_d = sticky_q;
    stall_d  = stall_q;
    if (bus.flag_clr)  sticky_d = push ? push_flags : 4'h0;
    else if (push)     sticky_d = sticky_q | push_flags;
    if (bus.in_valid && !in_ready && (stall_q != '1)) stall_d = stall_q + STALL_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sticky_q <= '0;
      stall_q  <= '0;
    end else begin
      sticky_q <= sticky_d;
      stall_q  <= stall_d;
    end
  end

  assign bus.sticky_flags = sticky_q;
  assign bus.stall_cnt    = stall_q;
`else
  logic unused_flag_clr;
  assign unused_flag_clr  = bus.flag_clr;
  assign bus.sticky_flags = '0;
  assign bus.stall_cnt    = '0;
`endif
endmodule

// File: tb/tb_alu32_result_buf.sv
// Bench for alu32_result_buf: directed vector table, corner sequences and random traffic
// against a queue-based model of the buffer; works with or without ALU_RESULT_BUF_DEBUG_EN.
module tb_alu32_result_buf;
  localparam int DEPTH     = 4;
  localparam int STALL_W   = 8;
  localparam int STALL_MAX = (1 << STALL_W) - 1;
`ifdef ALU_RESULT_BUF_DEBUG_EN
  localparam bit DBG = 1'b1;
`else
  localparam bit DBG = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  alu32_result_buf_if #(.DEPTH(DEPTH), .STALL_W(STALL_W)) bus ();
  alu32_result_buf #(.DEPTH(DEPTH), .STALL_W(STALL_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard / model ----------------
  int          checks = 0;
  int          errors = 0;
  logic [39:0] exp_q[$];
  logic [3:0]  m_sticky = 4'h0;
  int          m_stall  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  // One clock of traffic: drive, check the pre-edge view, advance the model, check post-edge.
  task automatic step(input bit iv, input logic [31:0] d, input logic [3:0] f,
                      input logic [3:0] sel, input bit ordy, input bit fclr);
    bit ready_m, push_m, pop_m;
    @(negedge clk);
    bus.in_valid  = iv;
    bus.ALU_Out   = d;
    {bus.Z, bus.C, bus.V, bus.S} = f;
    bus.ALU_Sel   = sel;
    bus.out_ready = ordy;
    bus.flag_clr  = fclr;
    #1;
    ready_m = !rst && (exp_q.size() < DEPTH);
    chk("in_ready", bus.in_ready, ready_m);
    chk("out_valid", bus.out_valid, exp_q.size() != 0);
    chk("count", bus.count, exp_q.size());
    if (exp_q.size() != 0)
      chk("head", {bus.out_data, bus.out_flags, bus.out_sel}, exp_q[0]);
    push_m = iv && ready_m;
    pop_m  = ordy && (exp_q.size() != 0);
    if (rst) begin
      exp_q.delete();
      m_sticky = 4'h0;
      m_stall  = 0;
    end else begin
      if (pop_m) void'(exp_q.pop_front());
      if (push_m) exp_q.push_back({d, f, sel});
      if (push_m) m_sticky = fclr ? f : (m_sticky | f);
      else if (fclr) m_sticky = 4'h0;
      if (iv && !ready_m && m_stall < STALL_MAX) m_stall++;
    end
    @(posedge clk);
    #1;
    chk("sticky_flags", bus.sticky_flags, DBG ? m_sticky : 4'h0);
    chk("stall_cnt", bus.stall_cnt, DBG ? m_stall : 0);
  endtask

  typedef struct {
    bit          iv;
    logic [31:0] d;
    logic [3:0]  f;
    logic [3:0]  sel;
    bit          ordy;
    bit          fclr;
    int          exp_cnt;
    logic [3:0]  exp_sticky;
  } vec_t;

  vec_t vecs[14];

  initial begin
    bus.in_valid = 1'b0; bus.ALU_Out = '0; bus.Z = 1'b0; bus.C = 1'b0; bus.V = 1'b0;
    bus.S = 1'b0; bus.ALU_Sel = '0; bus.out_ready = 1'b0; bus.flag_clr = 1'b0;

    // iv, data, flags, sel, out_ready, flag_clr, count after edge, sticky after edge
    vecs[0]  = '{1'b1, 32'h0000_0003, 4'b0000, 4'h0, 1'b0, 1'b0, 1, 4'b0000};
    vecs[1]  = '{1'b0, 32'h0000_0000, 4'b0000, 4'h0, 1'b0, 1'b0, 1, 4'b0000};
    vecs[2]  = '{1'b0, 32'h0000_0000, 4'b0000, 4'h0, 1'b1, 1'b0, 0, 4'b0000};
    vecs[3]  = '{1'b1, 32'h0000_0003, 4'b1000, 4'h1, 1'b0, 1'b0, 1, 4'b1000};
    vecs[4]  = '{1'b1, 32'hFFFF_FFFF, 4'b0001, 4'h2, 1'b0, 1'b0, 2, 4'b1001};
    vecs[5]  = '{1'b1, 32'h0000_0000, 4'b0100, 4'h3, 1'b0, 1'b1, 3, 4'b0100};
    vecs[6]  = '{1'b1, 32'hFFFF_FFFF, 4'b0010, 4'h4, 1'b0, 1'b0, 4, 4'b0110};
    vecs[7]  = '{1'b1, 32'h0000_0006, 4'b1111, 4'h5, 1'b0, 1'b0, 4, 4'b0110};
    vecs[8]  = '{1'b1, 32'h0000_0006, 4'b1111, 4'h5, 1'b0, 1'b0, 4, 4'b0110};
    vecs[9]  = '{1'b0, 32'h0000_0000, 4'b0000, 4'h0, 1'b0, 1'b1, 4, 4'b0000};
    vecs[10] = '{1'b0, 32'h0000_0000, 4'b0000, 4'h0, 1'b1, 1'b0, 3, 4'b0000};
    vecs[11] = '{1'b0, 32'h0000_0000, 4'b0000, 4'h0, 1'b1, 1'b0, 2, 4'b0000};
    vecs[12] = '{1'b0, 32'h0000_0000, 4'b0000, 4'h0, 1'b1, 1'b0, 1, 4'b0000};
    vecs[13] = '{1'b0, 32'h0000_0000, 4'b0000, 4'h0, 1'b1, 1'b0, 0, 4'b0000};

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", bus.count, 0);
    chk("rst_out_valid", bus.out_valid, 1'b0);
    chk("rst_in_ready", bus.in_ready, 1'b0);
    chk("rst_sticky", bus.sticky_flags, 4'h0);
    chk("rst_stall", bus.stall_cnt, 0);
    rst = 1'b0;
    #1;
    chk("post_rst_in_ready", bus.in_ready, 1'b1);

    // Directed table: single entry, fill/stall, sticky flags, drain order
    for (int i = 0; i < 14; i++) begin
      step(vecs[i].iv, vecs[i].d, vecs[i].f, vecs[i].sel, vecs[i].ordy, vecs[i].fclr);
      chk($sformatf("vec%0d_count", i), bus.count, vecs[i].exp_cnt);
      chk($sformatf("vec%0d_sticky", i), bus.sticky_flags, DBG ? vecs[i].exp_sticky : 4'h0);
    end
    chk("table_stall", bus.stall_cnt, DBG ? 2 : 0);

    // Simultaneous push/pop at count 2 across pointer wrap
    step(1'b1, 32'hA000_0001, 4'b0011, 4'h6, 1'b0, 1'b0);
    step(1'b1, 32'hA000_0002, 4'b0101, 4'h7, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, $urandom, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 1'b1, 1'b0);
      chk($sformatf("pp%0d_count", i), bus.count, 2);
    end
    repeat (2) step(1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0);

    // Stall counter saturation while full
    for (int i = 0; i < DEPTH; i++)
      step(1'b1, 32'hB000_0000 + i, 4'h0, 4'(i), 1'b0, 1'b0);
    repeat (STALL_MAX + 5) step(1'b1, 32'hDEAD_BEEF, 4'hF, 4'hF, 1'b0, 1'b0);
    chk("stall_saturated", bus.stall_cnt, DBG ? STALL_MAX : 0);

    // Reset mid-stream at count 3 with in_valid high
    step(1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("pre_rst_count", bus.count, 3);
    rst = 1'b1;
    step(1'b1, 32'h1234_5678, 4'hF, 4'h9, 1'b1, 1'b0);
    chk("mid_rst_count", bus.count, 0);
    chk("mid_rst_out_valid", bus.out_valid, 1'b0);
    chk("mid_rst_in_ready", bus.in_ready, 1'b0);
    chk("mid_rst_stall", bus.stall_cnt, 0);
    rst = 1'b0;
    #1;
    chk("after_rst_in_ready", bus.in_ready, 1'b1);

    // Random traffic against the model
    for (int i = 0; i < 400; i++)
      step(1'($urandom_range(0, 1)), $urandom, 4'($urandom_range(0, 15)),
           4'($urandom_range(0, 15)), $urandom_range(0, 2) != 0, $urandom_range(0, 7) == 0);
    repeat (DEPTH + 1) step(1'b0, 32'h0, 4'h0, 4'h0, 1'b1, 1'b0);
    chk("final_count", bus.count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
